led_trail_pwm: RTL

Downstream stage of the 4-LED running-light sequencer. It takes the one-hot LED pattern (`led_in[3:0]`) and drives the physical LEDs through a per-channel 4-bit brightness register and a shared PWM. The lit LED shows at full brightness. Each LED that has just gone dark fades out linearly, which gives the running light a "comet tail".

---
 rtl/led_trail_pwm.sv | 67 ++++++
 1 files changed

// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: each channel loads full brightness while its input is lit,
// then fades linearly on a shared decay tick; a shared 4-bit PWM renders brightness.
module led_trail_pwm #(
  parameter int PWM_DIV   = 50,
  parameter int DECAY_CNT = 2_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] led_in,
  output logic [3:0] led_out
);

  localparam logic [24:0] PRE_MAX = 25'(PWM_DIV - 1);
  localparam logic [24:0] DEC_MAX = 25'(DECAY_CNT - 1);

  logic [24:0]     pre_cnt_q, pre_cnt_d;
  logic [3:0]      pwm_cnt_q, pwm_cnt_d;
  logic [24:0]     dec_cnt_q, dec_cnt_d;
  logic [3:0][3:0] bright_q, bright_d;
  logic [3:0]      led_out_q, led_out_d;
  logic            pwm_tick;
  logic            decay_tick;

  // Brightness floors at zero so a faded channel never wraps back to full.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  assign pwm_tick   = (pre_cnt_q == PRE_MAX);
  assign decay_tick = (dec_cnt_q == DEC_MAX);

  always_comb begin
    pre_cnt_d = pwm_tick   ? 25'd0 : pre_cnt_q + 25'd1;
    dec_cnt_d = decay_tick ? 25'd0 : dec_cnt_q + 25'd1;
    pwm_cnt_d = pwm_tick   ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
    bright_d  = bright_q;
    led_out_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      // Load beats decay when both land on the same cycle.
      if (led_in[i]) begin
        bright_d[i] = 4'd15;
      end else if (decay_tick) begin
        bright_d[i] = sat_dec(bright_q[i]);
      end
      led_out_d[i] = (pwm_cnt_q < bright_q[i]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt_q <= 25'd0;
      pwm_cnt_q <= 4'd0;
      dec_cnt_q <= 25'd0;
      bright_q  <= '0;
      led_out_q <= 4'b0000;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      bright_q  <= bright_d;
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule
